// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl
//  Purpose  : Interrupt controller with up to eight channels. Each channel
//             can be synchronised, is level- or edge-sensitive and can use
//             either polarity. Detected events latch into a pending (STATUS)
//             register. Pending channels that are enabled in MASK drive a
//             registered aggregate interrupt.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1         single clock, rising edge
//    rst      in   1         synchronous active-high reset
//    csr_a    in   5         CSR address
//    csr_di   in   8         CSR write data
//    csr_we   in   1         CSR write strobe (one-cycle qualifier)
//    csr_do   out  8         CSR read data, zero when not addressed
//    irq_in   in   NUM_IRQS  interrupt sources
//    irq_out  out  1         registered aggregate interrupt (active high)
//
//  Register map (offset from BASE_ADDR)
//    +0 STATUS  pending bits, write-1-to-clear
//    +1 MASK    per-channel enable for irq_out
//    +2 MODE    1 = edge, 0 = level
//    +3 POL     1 = active-low / falling, 0 = active-high / rising
// ============================================================================
module irq_ctrl #(
  parameter logic [4:0] BASE_ADDR = 5'h00,
  parameter int         NUM_IRQS  = 8,
  parameter int         SYNC      = 1,
  parameter logic [7:0] DFL_MASK  = 8'h00,
  parameter logic [7:0] DFL_MODE  = 8'h00,
  parameter logic [7:0] DFL_POL   = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  input  logic [NUM_IRQS-1:0] irq_in,
  output logic                irq_out
);

  // Ones on implemented channels. Every register is held at 8 bits and
  // ANDed with this mask, so unimplemented bits stay constant zero.
  localparam logic [7:0] c_IMPL = 8'((9'd1 << NUM_IRQS) - 9'd1);

  localparam logic [1:0] c_OFF_STATUS = 2'd0;
  localparam logic [1:0] c_OFF_MASK   = 2'd1;
  localparam logic [1:0] c_OFF_MODE   = 2'd2;
  localparam logic [1:0] c_OFF_POL    = 2'd3;

  // --------------------------------------------------------------------------
  // CSR address decode
  // --------------------------------------------------------------------------
  // The subtraction uses 6 bits. An address below BASE_ADDR then wraps to a
  // value of 33 or more. This keeps it outside the 0..3 window, and the
  // window also works when BASE_ADDR is near the top of the address space.
  logic [5:0] w_off6;
  logic       w_hit;
  logic [1:0] w_sel;

  assign w_off6 = {1'b0, csr_a} - {1'b0, BASE_ADDR};
  assign w_hit  = (w_off6[5:2] == 4'd0);
  assign w_sel  = w_off6[1:0];

  logic w_wr_status;
  logic w_wr_mask;
  logic w_wr_mode;
  logic w_wr_pol;

  assign w_wr_status = csr_we && w_hit && (w_sel == c_OFF_STATUS);
  assign w_wr_mask   = csr_we && w_hit && (w_sel == c_OFF_MASK);
  assign w_wr_mode   = csr_we && w_hit && (w_sel == c_OFF_MODE);
  assign w_wr_pol    = csr_we && w_hit && (w_sel == c_OFF_POL);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic [7:0] w_irq;

  always_comb begin
    w_irq                 = 8'h00;
    w_irq[NUM_IRQS-1:0]   = irq_in;
  end

  // w_s is the per-channel sampled input that event detection uses.
  logic [7:0] w_s;

  generate
    if (SYNC != 0) begin : g_sync
      // Two-flop synchroniser. It has no reset, so it keeps tracking the
      // pins while rst is asserted.
      logic [7:0] r_meta;
      logic [7:0] r_sync;

      always_ff @(posedge clk) begin
        r_meta <= w_irq;
        r_sync <= r_meta;
      end

      assign w_s = r_sync;
    end else begin : g_nosync
      assign w_s = w_irq;
    end
  endgenerate

  // Value of w_s in the previous cycle, used for edge detection. It has no
  // reset on purpose. If it were cleared, an input held active through
  // reset would look like a fresh edge when reset is released.
  logic [7:0] r_prev;

  always_ff @(posedge clk) begin
    r_prev <= w_s;
  end

  // --------------------------------------------------------------------------
  // Event detection
  // --------------------------------------------------------------------------
  logic [7:0] r_status;
  logic [7:0] r_mask;
  logic [7:0] r_mode;
  logic [7:0] r_pol;
  logic       r_irq_out;

  logic [7:0] w_level;
  logic [7:0] w_rise;
  logic [7:0] w_fall;
  logic [7:0] w_edge;
  logic [7:0] w_event;

  assign w_level = w_s ^ r_pol;
  // Edges are taken from the raw sample history, not from w_level. As a
  // result, changing POL by itself can never produce an edge event.
  assign w_rise  = ~r_prev & w_s;
  assign w_fall  = r_prev & ~w_s;
  assign w_edge  = (~r_pol & w_rise) | (r_pol & w_fall);
  assign w_event = ((r_mode & w_edge) | (~r_mode & w_level)) & c_IMPL;

  // Bits to clear on a STATUS write.
  logic [7:0] w_w1c;

  assign w_w1c = w_wr_status ? (csr_di & c_IMPL) : 8'h00;

  // --------------------------------------------------------------------------
  // Register file and aggregate output
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status  <= 8'h00;
      r_mask    <= DFL_MASK & c_IMPL;
      r_mode    <= DFL_MODE & c_IMPL;
      r_pol     <= DFL_POL & c_IMPL;
      r_irq_out <= 1'b0;
    end else begin
      // The event term is ORed in after the clear, so a new event wins
      // over a write-1-to-clear on the same bit in the same cycle.
      r_status <= (r_status & ~w_w1c) | w_event;

      if (w_wr_mask) begin
        r_mask <= csr_di & c_IMPL;
      end
      if (w_wr_mode) begin
        r_mode <= csr_di & c_IMPL;
      end
      if (w_wr_pol) begin
        r_pol <= csr_di & c_IMPL;
      end

      r_irq_out <= |(r_status & r_mask);
    end
  end

  assign irq_out = r_irq_out;

  // --------------------------------------------------------------------------
  // Read mux. It drives zero when this block is not addressed, so several
  // blocks can share a bus through an OR.
  // --------------------------------------------------------------------------
  always_comb begin
    csr_do = 8'h00;
    if (w_hit) begin
      case (w_sel)
        c_OFF_STATUS: csr_do = r_status;
        c_OFF_MASK:   csr_do = r_mask;
        c_OFF_MODE:   csr_do = r_mode;
        c_OFF_POL:    csr_do = r_pol;
        default:      csr_do = 8'h00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_ctrl
//  Purpose  : Self-checking bench for irq_ctrl. It runs three instances that
//             share one stimulus bus:
//               u_s1 : 8 channels, synchronised, BASE 0x00
//               u_s0 : 8 channels, unsynchronised, BASE 0x00
//               u_n4 : 4 channels, synchronised, BASE 0x08, non-zero defaults
//             A behavioural model tracks all three instances.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic [4:0] csr_a  = 5'h00;
  logic [7:0] csr_di = 8'h00;
  logic       csr_we = 1'b0;
  logic [7:0] irq_in = 8'h00;

  logic [7:0] do_s1, do_s0, do_n4;
  logic       irq_s1, irq_s0, irq_n4;
  logic [7:0] dut_do [3];
  logic       dut_irq[3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.BASE_ADDR(5'h00), .NUM_IRQS(8), .SYNC(1),
             .DFL_MASK(8'h00), .DFL_MODE(8'h05), .DFL_POL(8'h00)) u_s1 (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(do_s1), .irq_in(irq_in), .irq_out(irq_s1));

  irq_ctrl #(.BASE_ADDR(5'h00), .NUM_IRQS(8), .SYNC(0),
             .DFL_MASK(8'h00), .DFL_MODE(8'h00), .DFL_POL(8'h00)) u_s0 (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(do_s0), .irq_in(irq_in), .irq_out(irq_s0));

  irq_ctrl #(.BASE_ADDR(5'h08), .NUM_IRQS(4), .SYNC(1),
             .DFL_MASK(8'hF3), .DFL_MODE(8'h0A), .DFL_POL(8'h05)) u_n4 (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(do_n4), .irq_in(irq_in[3:0]), .irq_out(irq_n4));

  always_comb dut_do  = '{do_s1, do_s0, do_n4};
  always_comb dut_irq = '{irq_s1, irq_s0, irq_n4};

  // --------------------------------------------------------------------------
  // Reference model. Each instance sees its raw input samples through a
  // delay line. The pending, mask and output rules are applied per channel.
  // --------------------------------------------------------------------------
  int         m_base[3]  = '{0, 0, 8};
  int         m_lat [3]  = '{2, 0, 2};
  logic [7:0] m_nm  [3]  = '{8'hFF, 8'hFF, 8'h0F};
  logic [7:0] m_dmask[3] = '{8'h00, 8'h00, 8'hF3};
  logic [7:0] m_dmode[3] = '{8'h05, 8'h00, 8'h0A};
  logic [7:0] m_dpol [3] = '{8'h00, 8'h00, 8'h05};

  logic [7:0] m_status[3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] m_mask  [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] m_mode  [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] m_pol   [3] = '{8'h00, 8'h00, 8'h00};
  logic       m_irq   [3] = '{1'b0, 1'b0, 1'b0};
  // m_hist[k][j] holds the input sampled j+1 edges before the current edge.
  logic [7:0] m_hist  [3][3] = '{'{8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00},
                                 '{8'h00, 8'h00, 8'h00}};

  logic [7:0] md_cur, md_s, md_p, md_ev;
  logic       md_nirq;
  int         md_off;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      md_cur = irq_in & m_nm[k];
      if (m_lat[k] == 0) begin
        md_s = md_cur;
        md_p = m_hist[k][0];
      end else begin
        md_s = m_hist[k][m_lat[k]-1];
        md_p = m_hist[k][m_lat[k]];
      end
      md_ev = 8'h00;
      for (int b = 0; b < 8; b++) begin
        if (m_mode[k][b]) begin
          if (m_pol[k][b]) md_ev[b] = md_p[b] && !md_s[b];
          else             md_ev[b] = !md_p[b] && md_s[b];
        end else begin
          md_ev[b] = (md_s[b] != m_pol[k][b]);
        end
      end
      md_ev   = md_ev & m_nm[k];
      md_nirq = |(m_status[k] & m_mask[k]);
      md_off  = int'(csr_a) - m_base[k];

      m_hist[k][2] <= m_hist[k][1];
      m_hist[k][1] <= m_hist[k][0];
      m_hist[k][0] <= md_cur;

      if (rst) begin
        m_status[k] <= 8'h00;
        m_mask[k]   <= m_dmask[k] & m_nm[k];
        m_mode[k]   <= m_dmode[k] & m_nm[k];
        m_pol[k]    <= m_dpol[k] & m_nm[k];
        m_irq[k]    <= 1'b0;
      end else begin
        if (csr_we && md_off == 0) m_status[k] <= (m_status[k] & ~csr_di) | md_ev;
        else                       m_status[k] <= m_status[k] | md_ev;
        if (csr_we && md_off == 1) m_mask[k] <= csr_di & m_nm[k];
        if (csr_we && md_off == 2) m_mode[k] <= csr_di & m_nm[k];
        if (csr_we && md_off == 3) m_pol[k]  <= csr_di & m_nm[k];
        m_irq[k] <= md_nirq;
      end
    end
  end

  function automatic logic [7:0] model_rd(input int k, input logic [4:0] a);
    int off;
    off = int'(a) - m_base[k];
    case (off)
      0:       return m_status[k];
      1:       return m_mask[k];
      2:       return m_mode[k];
      3:       return m_pol[k];
      default: return 8'h00;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic csr_wr(input logic [4:0] a, input logic [7:0] d);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] exp_rst[3][4];
    exp_rst = '{'{8'h00, 8'h00, 8'h05, 8'h00},
                '{8'h00, 8'h00, 8'h00, 8'h00},
                '{8'h00, 8'h03, 8'h0A, 8'h05}};
    rst = 1'b1;
    tick(5);
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 4; r++) begin
        csr_a = 5'(m_base[k] + r);
        #1;
        n_tests++;
        if (dut_do[k] !== exp_rst[k][r]) begin
          n_fail++;
          $display("FAIL reset_reg inst%0d off%0d: got %h expected %h", k, r, dut_do[k], exp_rst[k][r]);
        end
      end
      n_tests++;
      if (dut_irq[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_irq inst%0d: got %b expected 0", k, dut_irq[k]);
      end
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_level_sync();
    csr_wr(5'h02, 8'h00);
    csr_wr(5'h03, 8'h00);
    csr_wr(5'h01, 8'h01);
    csr_wr(5'h00, 8'hFF);
    irq_in[0] = 1'b1;
    csr_a = 5'h00;
    tick(1);
    n_tests++;
    if (do_s0 !== 8'h01) begin n_fail++; $display("FAIL lvl_s0_status: got %h expected 01", do_s0); end
    tick(1);
    n_tests++;
    if (do_s1 !== 8'h00) begin n_fail++; $display("FAIL lvl_s1_early: got %h expected 00", do_s1); end
    n_tests++;
    if (irq_s0 !== 1'b1) begin n_fail++; $display("FAIL lvl_s0_irq: got %b expected 1", irq_s0); end
    tick(1);
    n_tests++;
    if (do_s1 !== 8'h01) begin n_fail++; $display("FAIL lvl_s1_status: got %h expected 01", do_s1); end
    n_tests++;
    if (irq_s1 !== 1'b0) begin n_fail++; $display("FAIL lvl_s1_irq_early: got %b expected 0", irq_s1); end
    tick(1);
    n_tests++;
    if (irq_s1 !== 1'b1) begin n_fail++; $display("FAIL lvl_s1_irq: got %b expected 1", irq_s1); end
    csr_wr(5'h00, 8'h01);
    #1;
    n_tests++;
    if (do_s1 !== 8'h01) begin n_fail++; $display("FAIL lvl_w1c_reset: got %h expected 01", do_s1); end
    irq_in[0] = 1'b0;
    tick(3);
    csr_wr(5'h00, 8'hFF);
    #1;
    n_tests++;
    if (do_s1 !== 8'h00) begin n_fail++; $display("FAIL lvl_cleared: got %h expected 00", do_s1); end
  endtask

  task automatic test_edge_pulse();
    csr_wr(5'h02, 8'h02);
    csr_wr(5'h01, 8'h02);
    irq_in[1] = 1'b1;
    tick(1);
    irq_in[1] = 1'b0;
    tick(4);
    csr_a = 5'h00;
    #1;
    n_tests++;
    if (do_s0 !== 8'h02) begin n_fail++; $display("FAIL edge_s0_held: got %h expected 02", do_s0); end
    n_tests++;
    if (do_s1 !== 8'h02) begin n_fail++; $display("FAIL edge_s1_held: got %h expected 02", do_s1); end
    n_tests++;
    if (irq_s0 !== 1'b1) begin n_fail++; $display("FAIL edge_s0_irq: got %b expected 1", irq_s0); end
    csr_wr(5'h00, 8'h02);
    #1;
    n_tests++;
    if (do_s0 !== 8'h00) begin n_fail++; $display("FAIL edge_w1c: got %h expected 00", do_s0); end
    tick(1);
    n_tests++;
    if (irq_s0 !== 1'b0) begin n_fail++; $display("FAIL edge_irq_fall: got %b expected 0", irq_s0); end
  endtask

  task automatic test_falling_pol();
    csr_wr(5'h02, 8'h04);
    csr_wr(5'h03, 8'h04);
    csr_wr(5'h00, 8'hFF);
    irq_in[2] = 1'b1;
    tick(4);
    csr_a = 5'h00;
    #1;
    n_tests++;
    if (do_s1 !== 8'h00) begin n_fail++; $display("FAIL fall_no_rise: got %h expected 00", do_s1); end
    irq_in[2] = 1'b0;
    tick(4);
    n_tests++;
    if (do_s1 !== 8'h04) begin n_fail++; $display("FAIL fall_s1: got %h expected 04", do_s1); end
    n_tests++;
    if (do_s0 !== 8'h04) begin n_fail++; $display("FAIL fall_s0: got %h expected 04", do_s0); end
    csr_wr(5'h00, 8'h04);
    tick(1);
    csr_wr(5'h03, 8'h00);
    tick(3);
    csr_a = 5'h00;
    #1;
    n_tests++;
    if (do_s1 !== 8'h00) begin n_fail++; $display("FAIL pol_change_s1: got %h expected 00", do_s1); end
    n_tests++;
    if (do_s0 !== 8'h00) begin n_fail++; $display("FAIL pol_change_s0: got %h expected 00", do_s0); end
  endtask

  task automatic test_set_wins();
    csr_wr(5'h02, 8'h08);
    csr_wr(5'h03, 8'h00);
    csr_wr(5'h00, 8'hFF);
    irq_in[3] = 1'b1;
    csr_a = 5'h00;
    tick(1);
    n_tests++;
    if (do_s0 !== 8'h08) begin n_fail++; $display("FAIL setwin_pre: got %h expected 08", do_s0); end
    irq_in[3] = 1'b0;
    tick(1);
    irq_in[3] = 1'b1;
    csr_wr(5'h00, 8'h08);
    #1;
    n_tests++;
    if (do_s0 !== 8'h08) begin n_fail++; $display("FAIL setwin_same_cycle: got %h expected 08", do_s0); end
    csr_wr(5'h00, 8'h08);
    #1;
    n_tests++;
    if (do_s0 !== 8'h00) begin n_fail++; $display("FAIL setwin_plain_clear: got %h expected 00", do_s0); end
    irq_in[3] = 1'b0;
    tick(4);
  endtask

  task automatic test_nirq4();
    csr_wr(5'h09, 8'hFF);
    csr_a = 5'h09;
    #1;
    n_tests++;
    if (do_n4 !== 8'h0F) begin n_fail++; $display("FAIL n4_mask: got %h expected 0F", do_n4); end
    csr_a = 5'h0C;
    #1;
    n_tests++;
    if (do_n4 !== 8'h00) begin n_fail++; $display("FAIL n4_oob: got %h expected 00", do_n4); end
    csr_a = 5'h04;
    #1;
    n_tests++;
    if ((do_s1 | do_s0) !== 8'h00) begin n_fail++; $display("FAIL s_oob: got %h/%h expected 00", do_s1, do_s0); end
  endtask

  task automatic test_reset_mid();
    irq_in = 8'h00;
    csr_wr(5'h02, 8'h00);
    csr_wr(5'h03, 8'h00);
    tick(1);
    csr_wr(5'h00, 8'hFF);
    irq_in[0] = 1'b1;
    irq_in[2] = 1'b1;
    tick(4);
    csr_a = 5'h00;
    #1;
    n_tests++;
    if (do_s1 !== 8'h05) begin n_fail++; $display("FAIL rstmid_pre: got %h expected 05", do_s1); end
    csr_wr(5'h02, 8'h05);
    csr_wr(5'h01, 8'hFF);
    tick(2);
    rst = 1'b1;
    tick(1);
    csr_wr(5'h01, 8'h55);
    tick(1);
    csr_a = 5'h00;
    #1;
    n_tests++;
    if (do_s0 !== 8'h00) begin n_fail++; $display("FAIL rstmid_no_event: got %h expected 00", do_s0); end
    rst = 1'b0;
    tick(1);
    n_tests++;
    if (do_s1 !== 8'h00) begin n_fail++; $display("FAIL rstmid_s1_status: got %h expected 00", do_s1); end
    n_tests++;
    if (do_s0 !== 8'h05) begin n_fail++; $display("FAIL rstmid_s0_level: got %h expected 05", do_s0); end
    n_tests++;
    if (irq_s1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_irq: got %b expected 0", irq_s1); end
    csr_a = 5'h01;
    #1;
    n_tests++;
    if (do_s1 !== 8'h00) begin n_fail++; $display("FAIL rstmid_mask: got %h expected 00", do_s1); end
    tick(2);
    csr_a = 5'h00;
    #1;
    n_tests++;
    if (do_s1 !== 8'h00) begin n_fail++; $display("FAIL rstmid_no_edge: got %h expected 00", do_s1); end
    irq_in = 8'h00;
    tick(4);
  endtask

  task automatic test_random();
    for (int it = 0; it < 1500; it++) begin
      rst    = ($urandom_range(0, 199) == 0);
      csr_we = ($urandom_range(0, 3) == 0);
      csr_a  = 5'($urandom_range(0, 15));
      csr_di = 8'($urandom);
      if ($urandom_range(0, 2) == 0) irq_in = irq_in ^ (8'h01 << $urandom_range(0, 7));
      #1;
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (dut_do[k] !== model_rd(k, csr_a)) begin
          n_fail++;
          $display("FAIL rand_rd inst%0d it%0d a=%h: got %h expected %h", k, it, csr_a, dut_do[k], model_rd(k, csr_a));
        end
        n_tests++;
        if (dut_irq[k] !== m_irq[k]) begin
          n_fail++;
          $display("FAIL rand_irq inst%0d it%0d: got %b expected %b", k, it, dut_irq[k], m_irq[k]);
        end
      end
      @(negedge clk);
    end
    csr_we = 1'b0;
    rst    = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_level_sync();
    test_edge_pulse();
    test_falling_pol();
    test_set_wins();
    test_nirq4();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
